// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the FSM state enum and the x0 register constant.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN,
    MDU_WAIT
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// One DE source register against one stage destination.
// Ports: valid/uses/rs (DE side), rd/wb_en/is_load (stage side), match out.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic       uses,
  input  logic [4:0] rs,
  input  logic [4:0] rd,
  input  logic       wb_en,
  input  logic       is_load,
  output logic       match
);

  assign match = valid & uses & (rs != REG_ZERO)
               & is_load & wb_en & (rd == rs);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 6-stage core.
// Ports: DE deps, EX/M1 load info, MDU, redirect, mem waits in; hold/bubble, perf counters out.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   de_valid,
  input  logic [4:0]             de_rs1,
  input  logic [4:0]             de_rs2,
  input  logic                   de_uses_rs1,
  input  logic                   de_uses_rs2,
  input  logic [4:0]             ex_rd,
  input  logic [4:0]             m1_rd,
  input  logic                   ex_wb_en,
  input  logic                   m1_wb_en,
  input  logic                   ex_is_load,
  input  logic                   m1_is_load,
  input  logic                   ex_mdu_start,
  input  logic                   mdu_done,
  input  logic                   ex_redirect,
  input  logic                   imem_stall,
  input  logic                   dmem_stall,
  output logic                   pc_hold,
  output logic                   ifde_hold,
  output logic                   ifde_bubble,
  output logic                   deex_bubble,
  output logic                   ex_hold,
  output logic                   exm1_bubble,
  output logic                   back_hold,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  hz_state_t state, nxt_state;
  logic redirect_pending, nxt_pend;
  logic mdu_done_seen, nxt_seen;
  logic flush_inc;

  logic h1_ex, h1_m1, h2_ex, h2_m1;
  logic haz;
  logic done_any;
  logic freeze;
  logic mdu_park;

  hazard_cmp u_cmp_rs1_ex (
    .valid(de_valid), .uses(de_uses_rs1), .rs(de_rs1),
    .rd(ex_rd), .wb_en(ex_wb_en), .is_load(ex_is_load),
    .match(h1_ex)
  );

  hazard_cmp u_cmp_rs1_m1 (
    .valid(de_valid), .uses(de_uses_rs1), .rs(de_rs1),
    .rd(m1_rd), .wb_en(m1_wb_en), .is_load(m1_is_load),
    .match(h1_m1)
  );

  hazard_cmp u_cmp_rs2_ex (
    .valid(de_valid), .uses(de_uses_rs2), .rs(de_rs2),
    .rd(ex_rd), .wb_en(ex_wb_en), .is_load(ex_is_load),
    .match(h2_ex)
  );

  hazard_cmp u_cmp_rs2_m1 (
    .valid(de_valid), .uses(de_uses_rs2), .rs(de_rs2),
    .rd(m1_rd), .wb_en(m1_wb_en), .is_load(m1_is_load),
    .match(h2_m1)
  );

  assign haz      = h1_ex | h1_m1 | h2_ex | h2_m1;
  assign done_any = mdu_done | mdu_done_seen;
  assign freeze   = dmem_stall;
  assign mdu_park = !dmem_stall
                  & ((state == RUN && ex_mdu_start && !done_any)
                  |  (state == MDU_WAIT && !done_any));

  always_comb begin
    pc_hold     = 1'b0;
    ifde_hold   = 1'b0;
    ifde_bubble = 1'b0;
    deex_bubble = 1'b0;
    ex_hold     = 1'b0;
    exm1_bubble = 1'b0;
    back_hold   = 1'b0;
    nxt_state   = state;
    nxt_pend    = redirect_pending;
    nxt_seen    = mdu_done_seen;
    flush_inc   = 1'b0;
    unique case (1'b1)
      freeze: begin
        back_hold = 1'b1;
        ex_hold   = 1'b1;
        ifde_hold = 1'b1;
        pc_hold   = 1'b1;
        // remember a done pulse that lands while EX is frozen
        if (mdu_done && (state == MDU_WAIT || ex_mdu_start))
          nxt_seen = 1'b1;
      end
      mdu_park: begin
        ex_hold     = 1'b1;
        ifde_hold   = 1'b1;
        pc_hold     = 1'b1;
        exm1_bubble = 1'b1;
        if (state == RUN) begin
          nxt_state = MDU_WAIT;
          nxt_seen  = 1'b0;
        end
      end
      default: begin
        // release cycle or zero-wait op: result advances, done consumed
        if (state == MDU_WAIT || ex_mdu_start) begin
          nxt_state = RUN;
          nxt_seen  = 1'b0;
        end
        if (ex_redirect) begin
          ifde_bubble = 1'b1;
          deex_bubble = 1'b1;
          flush_inc   = 1'b1;
          nxt_pend    = imem_stall;
        end else if (redirect_pending) begin
          // drop fetches until the redirected one returns
          ifde_bubble = 1'b1;
          if (imem_stall) pc_hold = 1'b1;
          else            nxt_pend = 1'b0;
        end else if (haz) begin
          pc_hold     = 1'b1;
          ifde_hold   = 1'b1;
          deex_bubble = 1'b1;
        end else if (imem_stall) begin
          pc_hold     = 1'b1;
          ifde_bubble = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state            <= RUN;
      redirect_pending <= 1'b0;
      mdu_done_seen    <= 1'b0;
      stall_cycles     <= '0;
      flush_count      <= '0;
    end else begin
      state            <= nxt_state;
      redirect_pending <= nxt_pend;
      mdu_done_seen    <= nxt_seen;
      if (pc_hold)
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      if (flush_inc)
        flush_count <= flush_count + FLUSH_CNT_W'(1);
    end
  end

endmodule
